// File: rtl/agu_issue_arbiter_pkg.sv
// Shared types for the AGU issue arbiter.
//   agu_issue_t : one issue-slot packet; .valid qualifies the rest of the fields.
//   arb_state_e : arbiter FSM state (IDLE = normal issue, PEND = slot1 parked in hold buffer).
package agu_issue_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_instr2;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
  } agu_issue_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/agu_issue_arbiter_if.sv
// Bundle between the 2-issue front end / LSU and the AGU issue arbiter.
//   i_slot0_pkg    : older issue-slot packet
//   i_slot1_pkg    : younger issue-slot packet
//   i_lsu_ready    : LSU can accept a request this cycle
//   i_flush        : squash everything held or in flight
//   o_agu_pkg      : registered packet to the AGU operand inputs
//   o_stall        : issue stage must hold both slots this cycle
//   o_conflict_cnt : saturating count of dual-issue conflicts
//   o_dbg_state    : current arbiter FSM state
// Handshake: a slot packet is consumed on a rising edge only when its .valid
// is set and o_stall is low in that cycle; while o_stall is high the issuer
// must keep both slot packets unchanged. o_agu_pkg is consumed by the LSU
// on any edge where i_lsu_ready is high; otherwise it holds.
interface agu_issue_arbiter_if #(
  parameter int CNT_W = 16
);
  import agu_issue_arbiter_pkg::*;

  agu_issue_t         i_slot0_pkg;
  agu_issue_t         i_slot1_pkg;
  logic               i_lsu_ready;
  logic               i_flush;
  agu_issue_t         o_agu_pkg;
  logic               o_stall;
  logic [CNT_W-1:0]   o_conflict_cnt;
  arb_state_e         o_dbg_state;

  // Arbiter side
  modport slave (
    input  i_slot0_pkg, i_slot1_pkg, i_lsu_ready, i_flush,
    output o_agu_pkg, o_stall, o_conflict_cnt, o_dbg_state
  );

  // Front end / LSU side
  modport master (
    output i_slot0_pkg, i_slot1_pkg, i_lsu_ready, i_flush,
    input  o_agu_pkg, o_stall, o_conflict_cnt, o_dbg_state
  );

endinterface

// File: rtl/agu_issue_arbiter.sv
// Shares the single AGU between the two issue slots of the 2-issue front end.
// At most one packet per cycle leaves through a registered output stage.
// On a dual memory issue the younger (slot1) packet is parked in a one-entry
// hold buffer and issue is stalled for one cycle, so packets leave in program
// order. LSU backpressure freezes everything; flush squashes everything.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : agu_issue_arbiter_if.slave (slots, lsu ready, flush, outputs)
module agu_issue_arbiter
  import agu_issue_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  agu_issue_arbiter_if.slave   bus
);

  arb_state_e       r_state;
  agu_issue_t       r_out;
  agu_issue_t       r_hold;
  logic [CNT_W-1:0] r_cnt;

  arb_state_e       w_state_nxt;
  agu_issue_t       w_out_nxt;
  agu_issue_t       w_hold_nxt;
  logic             w_cnt_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_hold_nxt  = r_hold;
    w_cnt_inc   = 1'b0;

    if (bus.i_flush) begin
      // Flush wins even under backpressure; only valid bits are cleared.
      w_out_nxt.valid  = 1'b0;
      w_hold_nxt.valid = 1'b0;
      w_state_nxt      = IDLE;
    end else if (bus.i_lsu_ready) begin
      case (r_state)
        IDLE: begin
          if (bus.i_slot0_pkg.valid && bus.i_slot1_pkg.valid) begin
            w_out_nxt   = bus.i_slot0_pkg;
            w_hold_nxt  = bus.i_slot1_pkg;
            w_state_nxt = PEND;
            w_cnt_inc   = 1'b1;
          end else if (bus.i_slot0_pkg.valid) begin
            w_out_nxt = bus.i_slot0_pkg;
          end else if (bus.i_slot1_pkg.valid) begin
            w_out_nxt = bus.i_slot1_pkg;
          end else begin
            w_out_nxt.valid = 1'b0;
          end
        end
        PEND: begin
          // Slot inputs are stalled here, so the parked packet cannot be overtaken.
          w_out_nxt        = r_hold;
          w_hold_nxt.valid = 1'b0;
          w_state_nxt      = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Saturating conflict counter: sticks at all-ones, never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.o_agu_pkg      = r_out;
  assign bus.o_stall        = ~bus.i_lsu_ready | (r_state == PEND);
  assign bus.o_conflict_cnt = r_cnt;
  assign bus.o_dbg_state    = r_state;

endmodule

// File: tb/tb_agu_issue_arbiter.sv
module tb_agu_issue_arbiter;
  import agu_issue_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  agu_issue_arbiter_if #(.CNT_W(16)) if_a ();
  agu_issue_arbiter_if #(.CNT_W(2))  if_b ();

  agu_issue_arbiter #(.CNT_W(16)) u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if_a.slave)
  );

  agu_issue_arbiter #(.CNT_W(2)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if_b.slave)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic agu_issue_t mk(input logic v, input logic i2, input logic [31:0] pc,
                                    input logic [31:0] opa);
    agu_issue_t p;
    p           = '0;
    p.valid     = v;
    p.is_instr2 = i2;
    p.op        = 4'h3;
    p.pc        = pc;
    p.operand_a = opa;
    p.operand_b = 32'h55;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input agu_issue_t s0, input agu_issue_t s1);
    if_a.i_slot0_pkg = s0;
    if_a.i_slot1_pkg = s1;
  endtask

  task automatic idle_a();
    drive_a('0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst_n = 1'b0;
    idle_a();
    if_a.i_lsu_ready = 1'b1;
    if_a.i_flush     = 1'b0;
    if_b.i_slot0_pkg = '0;
    if_b.i_slot1_pkg = '0;
    if_b.i_lsu_ready = 1'b1;
    if_b.i_flush     = 1'b0;

    #3;
    check_eq("rst_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);
    check_eq("rst_cnt",   64'(if_a.o_conflict_cnt), 64'd0);
    check_eq("rst_stall", 64'(if_a.o_stall), 64'd0);
    check_eq("rst_state", 64'(if_a.o_dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single slot0 issue
    drive_a(mk(1'b1, 1'b0, 32'h100, 32'h100), mk(1'b0, 1'b0, 32'h0, 32'h0));
    #1 check_eq("s0_stall_pre", 64'(if_a.o_stall), 64'd0);
    tick();
    idle_a();
    check_eq("s0_valid", 64'(if_a.o_agu_pkg.valid), 64'd1);
    check_eq("s0_opa",   64'(if_a.o_agu_pkg.operand_a), 64'h100);
    check_eq("s0_pc",    64'(if_a.o_agu_pkg.pc), 64'h100);
    check_eq("s0_stall", 64'(if_a.o_stall), 64'd0);
    tick();
    check_eq("s0_drain_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);

    // single slot1 issue, is_instr2 passes through
    drive_a(mk(1'b0, 1'b0, 32'h0, 32'h0), mk(1'b1, 1'b1, 32'h204, 32'h30));
    tick();
    idle_a();
    check_eq("s1_valid", 64'(if_a.o_agu_pkg.valid), 64'd1);
    check_eq("s1_opa",   64'(if_a.o_agu_pkg.operand_a), 64'h30);
    check_eq("s1_instr2", 64'(if_a.o_agu_pkg.is_instr2), 64'd1);
    check_eq("s1_state", 64'(if_a.o_dbg_state), 64'(IDLE));
    tick();

    // dual issue: slot0 first, slot1 one cycle later
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h20);
    drive_a(mk(1'b1, 1'b0, 32'h300, 32'h10), mk(1'b1, 1'b1, 32'h304, 32'h20));
    tick();
    check_eq("dual_c1_opa",   64'(if_a.o_agu_pkg.operand_a), 64'(exp_q.pop_front()));
    check_eq("dual_c1_stall", 64'(if_a.o_stall), 64'd1);
    check_eq("dual_c1_state", 64'(if_a.o_dbg_state), 64'(PEND));
    check_eq("dual_c1_cnt",   64'(if_a.o_conflict_cnt), 64'd1);
    tick();
    idle_a();
    check_eq("dual_c2_opa",   64'(if_a.o_agu_pkg.operand_a), 64'(exp_q.pop_front()));
    check_eq("dual_c2_valid", 64'(if_a.o_agu_pkg.valid), 64'd1);
    check_eq("dual_c2_stall", 64'(if_a.o_stall), 64'd0);
    check_eq("dual_c2_cnt",   64'(if_a.o_conflict_cnt), 64'd1);
    tick();
    check_eq("dual_drain_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);

    // dual issue, then LSU backpressure for 3 cycles in PEND
    drive_a(mk(1'b1, 1'b0, 32'h400, 32'h10), mk(1'b1, 1'b0, 32'h404, 32'h20));
    tick();
    check_eq("bp_enter_state", 64'(if_a.o_dbg_state), 64'(PEND));
    if_a.i_lsu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_hold_opa",   64'(if_a.o_agu_pkg.operand_a), 64'h10);
      check_eq("bp_hold_stall", 64'(if_a.o_stall), 64'd1);
      check_eq("bp_hold_cnt",   64'(if_a.o_conflict_cnt), 64'd2);
    end
    if_a.i_lsu_ready = 1'b1;
    #1 check_eq("bp_ready_stall", 64'(if_a.o_stall), 64'd1);
    tick();
    idle_a();
    check_eq("bp_release_opa",   64'(if_a.o_agu_pkg.operand_a), 64'h20);
    check_eq("bp_release_state", 64'(if_a.o_dbg_state), 64'(IDLE));
    tick();

    // dual issue, then flush in PEND: parked packet is dropped
    drive_a(mk(1'b1, 1'b0, 32'h500, 32'h10), mk(1'b1, 1'b0, 32'h504, 32'h20));
    tick();
    if_a.i_flush = 1'b1;
    tick();
    if_a.i_flush = 1'b0;
    idle_a();
    check_eq("fl_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);
    check_eq("fl_state", 64'(if_a.o_dbg_state), 64'(IDLE));
    check_eq("fl_stall", 64'(if_a.o_stall), 64'd0);
    check_eq("fl_cnt",   64'(if_a.o_conflict_cnt), 64'd3);
    tick();
    check_eq("fl_no_slot1", 64'(if_a.o_agu_pkg.valid), 64'd0);

    // flush under backpressure; flush-cycle inputs are discarded
    drive_a(mk(1'b1, 1'b0, 32'h600, 32'h10), mk(1'b1, 1'b0, 32'h604, 32'h20));
    tick();
    if_a.i_lsu_ready = 1'b0;
    if_a.i_flush     = 1'b1;
    tick();
    if_a.i_flush = 1'b0;
    check_eq("flbp_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);
    check_eq("flbp_state", 64'(if_a.o_dbg_state), 64'(IDLE));
    check_eq("flbp_stall", 64'(if_a.o_stall), 64'd1);
    check_eq("flbp_cnt",   64'(if_a.o_conflict_cnt), 64'd4);
    if_a.i_lsu_ready = 1'b1;
    idle_a();
    // flush with fresh valid inputs: nothing accepted, counter unchanged
    drive_a(mk(1'b1, 1'b0, 32'h700, 32'h77), mk(1'b1, 1'b0, 32'h704, 32'h78));
    if_a.i_flush = 1'b1;
    tick();
    if_a.i_flush = 1'b0;
    idle_a();
    check_eq("fl_in_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);
    check_eq("fl_in_cnt",   64'(if_a.o_conflict_cnt), 64'd4);
    tick();

    // CNT_W=2: five back-to-back dual issues saturate at 3
    if_b.i_slot0_pkg = mk(1'b1, 1'b0, 32'h800, 32'h81);
    if_b.i_slot1_pkg = mk(1'b1, 1'b0, 32'h804, 32'h82);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("sat_cnt",  64'(if_b.o_conflict_cnt), 64'(sat_exp[i]));
      check_eq("sat_s0",   64'(if_b.o_agu_pkg.operand_a), 64'h81);
      tick();
      check_eq("sat_s1",   64'(if_b.o_agu_pkg.operand_a), 64'h82);
    end
    if_b.i_slot0_pkg = '0;
    if_b.i_slot1_pkg = '0;

    // async reset while in PEND
    drive_a(mk(1'b1, 1'b0, 32'h900, 32'h10), mk(1'b1, 1'b0, 32'h904, 32'h20));
    tick();
    idle_a();
    check_eq("rp_state_pre", 64'(if_a.o_dbg_state), 64'(PEND));
    if_a.i_lsu_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rp_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);
    check_eq("rp_stall", 64'(if_a.o_stall), 64'd1);
    check_eq("rp_cnt",   64'(if_a.o_conflict_cnt), 64'd0);
    check_eq("rp_state", 64'(if_a.o_dbg_state), 64'(IDLE));
    check_eq("rp_cnt_b", 64'(if_b.o_conflict_cnt), 64'd0);
    if_a.i_lsu_ready = 1'b1;
    #1 check_eq("rp_stall_rdy", 64'(if_a.o_stall), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rp_post_valid", 64'(if_a.o_agu_pkg.valid), 64'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
